// File: rtl/lab9_soc_nios2_dct_pkg.sv
// Shared definitions for the DCT trace packer.
// Holds atom codes, frame type codes, buffer geometry and the
// output frame register state encoding.
package lab9_soc_nios2_dct_pkg;

  localparam int DCT_SLOTS   = 15;
  localparam int DCT_CNT_W   = 4;
  localparam int DCT_BUF_W   = 2 * DCT_SLOTS;
  localparam int DCT_FRAME_W = 2 + DCT_CNT_W + DCT_BUF_W;

  localparam logic [1:0] ATOM_NOT_TAKEN = 2'b00;
  localparam logic [1:0] ATOM_TAKEN     = 2'b01;
  localparam logic [1:0] ATOM_CALL      = 2'b10;
  localparam logic [1:0] ATOM_RETURN    = 2'b11;

  // 2'b00 is reserved so a frame never looks like an all-zero idle word.
  localparam logic [1:0] TYPE_NORMAL = 2'b01;
  localparam logic [1:0] TYPE_OVF    = 2'b11;

  typedef enum logic {
    FRAME_EMPTY = 1'b0,
    FRAME_FULL  = 1'b1
  } frame_state_e;

endpackage

// File: rtl/lab9_soc_nios2_dct_frame_reg.sv
// One-entry valid/ready output register for trace frames.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   load, load_data    capture a new frame (only asserted when the entry is
//                      empty or being drained this cycle)
//   frame_ready        downstream accepts the held frame
//   frame_valid        entry holds a frame
//   frame_data         held frame, stable until accepted
module lab9_soc_nios2_dct_frame_reg
  import lab9_soc_nios2_dct_pkg::*;
#(
  parameter int W = DCT_FRAME_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         frame_ready,
  output logic         frame_valid,
  output logic [W-1:0] frame_data
);

  frame_state_e state_q, state_d;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FRAME_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) data_q <= load_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FRAME_EMPTY: if (load) state_d = FRAME_FULL;
      // A load alongside frame_ready keeps the entry full: one frame per cycle.
      FRAME_FULL:  if (frame_ready && !load) state_d = FRAME_EMPTY;
      default:     state_d = FRAME_EMPTY;
    endcase
  end

  assign frame_valid = (state_q == FRAME_FULL);
  assign frame_data  = data_q;

endmodule

// File: rtl/lab9_soc_nios2_qsys_0_dct_packer.sv
// DCT atom packer: gathers 2-bit direct-control-transfer atoms into a
// 15-slot buffer and hands closed buffers to the trace FIFO as 36-bit frames.
// The CPU is never stalled; atoms that cannot be stored are dropped and the
// next frame is marked as following an overflow.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   atom_valid, atom      one atom per cycle from the CPU trace port
//   flush                 close the current buffer (indirect branch, stop)
//   frame_ready           trace FIFO accepts a frame
//   frame_valid/_data     outgoing frame {type, count, data}
//   dct_buffer/dct_count  live packing buffer and fill count
//   overflow_pending      sticky dropped-atom flag
module lab9_soc_nios2_qsys_0_dct_packer
  import lab9_soc_nios2_dct_pkg::*;
#(
  parameter int SLOTS   = DCT_SLOTS,
  parameter int FRAME_W = DCT_FRAME_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 atom_valid,
  input  logic [1:0]           atom,
  input  logic                 flush,
  input  logic                 frame_ready,
  output logic                 frame_valid,
  output logic [FRAME_W-1:0]   frame_data,
  output logic [2*SLOTS-1:0]   dct_buffer,
  output logic [3:0]           dct_count,
  output logic                 overflow_pending
);

  localparam int BUF_W = 2 * SLOTS;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOTS);

  function automatic logic [BUF_W-1:0] insert_atom(
    input logic [BUF_W-1:0] b,
    input logic [CNT_W-1:0] slot,
    input logic [1:0]       a
  );
    logic [BUF_W-1:0] ext;
    ext = {{(BUF_W-2){1'b0}}, a};
    return b | (ext << {slot, 1'b0});
  endfunction

  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               ovf_q, ovf_d;

  logic               reg_free, held, blocked, drop, close, ovf_accept;
  logic [1:0]         frame_type;
  logic [BUF_W-1:0]   ins_buf;
  logic [CNT_W-1:0]   ins_cnt;
  logic               load;
  logic [FRAME_W-1:0] load_data;

  assign reg_free   = !frame_valid || frame_ready;
  // Count 15 means the buffer is already closed and only waits to move.
  assign held       = (cnt_q == CNT_FULL);
  assign blocked    = held && !reg_free;
  assign frame_type = ovf_q ? TYPE_OVF : TYPE_NORMAL;
  assign ins_buf    = atom_valid ? insert_atom(buf_q, cnt_q, atom) : buf_q;
  assign ins_cnt    = cnt_q + {{(CNT_W-1){1'b0}}, atom_valid};
  assign close      = (ins_cnt == CNT_FULL) ||
                      ((flush || pend_q) && (ins_cnt != '0));
  assign ovf_accept = frame_valid && frame_ready &&
                      (frame_data[FRAME_W-1 -: 2] == TYPE_OVF);

  always_comb begin
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    load      = 1'b0;
    load_data = {frame_type, cnt_q, buf_q};
    drop      = 1'b0;
    if (blocked) begin
      drop = atom_valid;
    end else if (held) begin
      // Held buffer moves out; a same-cycle atom starts the fresh buffer.
      load   = 1'b1;
      buf_d  = atom_valid ? {{(BUF_W-2){1'b0}}, atom} : '0;
      cnt_d  = {{(CNT_W-1){1'b0}}, atom_valid};
      pend_d = flush && atom_valid;
    end else if (close && reg_free) begin
      load      = 1'b1;
      load_data = {frame_type, ins_cnt, ins_buf};
      buf_d     = '0;
      cnt_d     = '0;
      pend_d    = 1'b0;
    end else begin
      buf_d  = ins_buf;
      cnt_d  = ins_cnt;
      // A full buffer closes by itself, so a remembered flush is not needed.
      pend_d = (flush || pend_q) && (ins_cnt != '0) && (ins_cnt != CNT_FULL);
    end
    // A drop in the same cycle as the clearing acceptance keeps the flag set.
    ovf_d = drop || (ovf_q && !ovf_accept);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  lab9_soc_nios2_dct_frame_reg #(.W(FRAME_W)) u_frame_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_data   (load_data),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .frame_data  (frame_data)
  );

  assign dct_buffer       = buf_q;
  assign dct_count        = cnt_q;
  assign overflow_pending = ovf_q;

endmodule

// File: tb/tb_lab9_soc_nios2_qsys_0_dct_packer.sv
module tb_lab9_soc_nios2_qsys_0_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom = 2'b00;
  logic        flush = 1'b0;
  logic        frame_ready = 1'b0;
  logic        frame_valid;
  logic [35:0] frame_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow_pending;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: buffer as a queue of atoms plus a one-entry frame slot.
  logic [1:0]  mq[$];
  bit          m_pend, m_ovf, m_fv;
  logic [35:0] m_fd;

  always #5 clk = ~clk;

  lab9_soc_nios2_qsys_0_dct_packer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .atom_valid       (atom_valid),
    .atom             (atom),
    .flush            (flush),
    .frame_ready      (frame_ready),
    .frame_valid      (frame_valid),
    .frame_data       (frame_data),
    .dct_buffer       (dct_buffer),
    .dct_count        (dct_count),
    .overflow_pending (overflow_pending)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] packv();
    logic [29:0] v = '0;
    foreach (mq[i]) v[2*i +: 2] = mq[i];
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pend = 0; m_ovf = 0; m_fv = 0; m_fd = '0;
  endtask

  task automatic model_next(input bit av, input logic [1:0] a, input bit fl, input bit rdy);
    bit free, clr, set, load;
    logic [35:0] ld;
    logic [1:0] typ;
    free = !m_fv || rdy;
    clr  = m_fv && rdy && (m_fd[35:34] == 2'b11);
    typ  = m_ovf ? 2'b11 : 2'b01;
    set = 0; load = 0; ld = '0;
    if (mq.size() == 15 && !free) begin
      if (av) set = 1;
    end else if (mq.size() == 15) begin
      load = 1; ld = {typ, 4'd15, packv()};
      mq.delete();
      if (av) mq.push_back(a);
      m_pend = fl && av;
    end else begin
      if (av) mq.push_back(a);
      if ((mq.size() == 15 || ((fl || m_pend) && mq.size() > 0)) && free) begin
        load = 1; ld = {typ, 4'(mq.size()), packv()};
        mq.delete();
        m_pend = 0;
      end else begin
        m_pend = (fl || m_pend) && mq.size() > 0 && mq.size() < 15;
      end
    end
    if (load) begin m_fv = 1; m_fd = ld; end
    else if (rdy) m_fv = 0;
    m_ovf = set || (m_ovf && !clr);
  endtask

  task automatic compare_all();
    chk("frame_valid", 64'(frame_valid), 64'(m_fv));
    chk("frame_data", 64'(frame_data), 64'(m_fd));
    chk("dct_buffer", 64'(dct_buffer), 64'(packv()));
    chk("dct_count", 64'(dct_count), 64'(mq.size()));
    chk("overflow_pending", 64'(overflow_pending), 64'(m_ovf));
  endtask

  task automatic step(input bit av, input logic [1:0] a, input bit fl, input bit rdy);
    atom_valid = av; atom = a; flush = fl; frame_ready = rdy;
    model_next(av, a, fl, rdy);
    @(posedge clk); #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset frame_valid", 64'(frame_valid), 64'd0);
    chk("reset frame_data", 64'(frame_data), 64'd0);
    chk("reset dct_count", 64'(dct_count), 64'd0);
    chk("reset overflow", 64'(overflow_pending), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // 15 taken atoms, ready high
    for (int i = 0; i < 15; i++) begin
      step(1, 2'b01, 0, 1);
      if (i == 13) chk("t1 buffer14", 64'(dct_buffer), 64'h0555_5555);
    end
    chk("t1 frame_valid", 64'(frame_valid), 64'd1);
    chk("t1 frame_data", 64'(frame_data), 64'({2'b01, 4'hF, 30'h1555_5555}));
    chk("t1 dct_count", 64'(dct_count), 64'd0);
    step(0, 2'b00, 0, 1);

    // 3 atoms then flush; then a zero-count flush
    step(1, 2'b01, 0, 1);
    step(1, 2'b10, 0, 1);
    step(1, 2'b11, 0, 1);
    step(0, 2'b00, 1, 1);
    chk("t2 frame_data", 64'(frame_data), 64'({2'b01, 4'h3, 30'h39}));
    step(0, 2'b00, 1, 1);
    chk("t2 empty flush", 64'(frame_valid), 64'd0);

    // atom + flush in the same cycle
    step(1, 2'b01, 0, 1);
    step(1, 2'b00, 0, 1);
    step(1, 2'b10, 1, 1);
    chk("t3 frame_data", 64'(frame_data), 64'({2'b01, 4'h3, 30'h21}));
    step(0, 2'b00, 0, 1);

    // back-pressure and overflow
    for (int i = 0; i < 32; i++) step(1, 2'b01, 0, 0);
    chk("t4 held frame", 64'(frame_data), 64'({2'b01, 4'hF, 30'h1555_5555}));
    chk("t4 dct_count", 64'(dct_count), 64'd15);
    chk("t4 overflow", 64'(overflow_pending), 64'd1);
    step(0, 2'b00, 0, 1);
    chk("t4 second frame", 64'(frame_data), 64'({2'b11, 4'hF, 30'h1555_5555}));
    chk("t4 second valid", 64'(frame_valid), 64'd1);
    step(0, 2'b00, 0, 1);
    chk("t4 overflow cleared", 64'(overflow_pending), 64'd0);

    // flush remembered while frame register is busy
    for (int i = 0; i < 15; i++) step(1, 2'b10, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 2'b01, 0, 0);
    step(0, 2'b00, 1, 0);
    step(1, 2'b11, 0, 0);
    step(1, 2'b11, 0, 0);
    step(0, 2'b00, 0, 1);
    chk("t5 frame count", 64'(frame_data[33:30]), 64'd6);
    step(0, 2'b00, 0, 1);

    // asynchronous reset mid-buffer
    for (int i = 0; i < 15; i++) step(1, 2'b01, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 2'b10, 0, 0);
    chk("t6 count before reset", 64'(dct_count), 64'd7);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("t6 frame_valid", 64'(frame_valid), 64'd0);
    chk("t6 frame_data", 64'(frame_data), 64'd0);
    chk("t6 dct_buffer", 64'(dct_buffer), 64'd0);
    chk("t6 dct_count", 64'(dct_count), 64'd0);
    chk("t6 overflow", 64'(overflow_pending), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 2'b00, 0, 1);
    chk("t6 no frame after reset", 64'(frame_valid), 64'd0);

    // randomized traffic in phases of differing back-pressure
    for (int ph = 0; ph < 12; ph++) begin
      int rdy_pct, av_pct, fl_pct;
      rdy_pct = (ph % 3 == 0) ? 100 : (ph % 3 == 1) ? 50 : 5;
      av_pct  = (ph % 2 == 0) ? 90 : 50;
      fl_pct  = (ph % 4 == 3) ? 30 : 8;
      for (int c = 0; c < 250; c++) begin
        step($urandom_range(99) < av_pct, 2'($urandom), $urandom_range(99) < fl_pct,
             $urandom_range(99) < rdy_pct);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
